path_metric_unit: RTL and testbench

Add-compare-select stage of the rate-1/2, K=4, 8-state Viterbi decoder. Each accepted step takes the 16 two-bit branch metrics produced by the eight branch-metric blocks, updates the eight stored path metrics and emits one survivor-decision byte per step to the traceback memory. Path metrics are normalised every step, so their width stays fixed.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/acs_node.sv | 27 ++
 rtl/path_metric_unit.sv | 122 ++++++++++++
 tb/tb_path_metric_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the 8-state, K=4 Viterbi decoder.
package viterbi_pkg;
   localparam int NSTATES = 8;
   localparam int BM_W    = 2;

   typedef struct packed {
      logic [BM_W-1:0] bm1;
      logic [BM_W-1:0] bm0;
   } bm_pair_t;

   // Predecessor k (0 = even, 1 = odd) of next state n.
   function automatic logic [2:0] pred(input logic [2:0] n, input logic k);
      return {n[1:0], k};
   endfunction

   function automatic logic branch_in(input logic [2:0] n);
      return n[2];
   endfunction
endpackage

// File: rtl/acs_node.sv
// One add-compare-select cell: saturating sums of both predecessors, pick the smaller.
module acs_node
   import viterbi_pkg::*;
#(
   parameter int PM_W = 5
) (
   input  logic [PM_W-1:0] pm_a,
   input  logic [PM_W-1:0] pm_c,
   input  logic [BM_W-1:0] bm_a,
   input  logic [BM_W-1:0] bm_c,
   output logic [PM_W-1:0] sum,
   output logic            sel
);
   logic [PM_W:0]   sa_wide;
   logic [PM_W:0]   sc_wide;
   logic [PM_W-1:0] sa;
   logic [PM_W-1:0] sc;

   assign sa_wide = {1'b0, pm_a} + {{(PM_W + 1 - BM_W){1'b0}}, bm_a};
   assign sc_wide = {1'b0, pm_c} + {{(PM_W + 1 - BM_W){1'b0}}, bm_c};
   assign sa      = sa_wide[PM_W] ? '1 : sa_wide[PM_W-1:0];
   assign sc      = sc_wide[PM_W] ? '1 : sc_wide[PM_W-1:0];

   // Strict compare: ties resolve to the even predecessor.
   assign sel = (sc < sa);
   assign sum = sel ? sc : sa;
endmodule

// File: rtl/path_metric_unit.sv
// ACS stage: updates eight normalised path metrics per step and emits survivor decisions.
module path_metric_unit
   import viterbi_pkg::*;
#(
   parameter int PM_W      = 5,
   parameter int INIT_PM   = 15,
   parameter int FRAME_LEN = 16,
   localparam int IDX_W    = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             bm_valid,
   input  logic [31:0]      bm_in,
   output logic             dec_valid,
   output logic [7:0]       dec_bits,
   output logic [IDX_W-1:0] dec_idx,
   output logic [2:0]       best_state,
   output logic             frame_done
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [PM_W-1:0]  INIT_V = PM_W'(INIT_PM);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(FRAME_LEN - 1);

   state_t state;
   state_t state_next;

   logic [PM_W-1:0]    pm      [NSTATES];
   logic [PM_W-1:0]    sums    [NSTATES];
   logic [PM_W-1:0]    pm_next [NSTATES];
   bm_pair_t           bm_pairs [NSTATES];
   logic [NSTATES-1:0] sel;
   logic [PM_W-1:0]    min_sum;
   logic [2:0]         min_idx;
   logic [IDX_W-1:0]   cnt;
   logic               accept;

   for (genvar p = 0; p < NSTATES; p++) begin : g_bm
      assign bm_pairs[p] = bm_in[4*p +: 4];
   end

   for (genvar n = 0; n < NSTATES; n++) begin : g_acs
      localparam logic [2:0] A  = pred(3'(n), 1'b0);
      localparam logic [2:0] C  = pred(3'(n), 1'b1);
      localparam logic       BR = branch_in(3'(n));
      acs_node #(.PM_W(PM_W)) u_acs (
         .pm_a (pm[A]),
         .pm_c (pm[C]),
         .bm_a (BR ? bm_pairs[A].bm1 : bm_pairs[A].bm0),
         .bm_c (BR ? bm_pairs[C].bm1 : bm_pairs[C].bm0),
         .sum  (sums[n]),
         .sel  (sel[n])
      );
   end

   // Strict less-than scan keeps the lowest index among equal minima.
   always_comb begin
      min_sum = sums[0];
      min_idx = 3'd0;
      for (int i = 1; i < NSTATES; i++) begin
         if (sums[i] < min_sum) begin
            min_sum = sums[i];
            min_idx = 3'(i);
         end
      end
      for (int i = 0; i < NSTATES; i++) begin
         pm_next[i] = sums[i] - min_sum;
      end
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = RUN;
      end
   end

   assign accept = (state == RUN) && bm_valid && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm[0] <= '0;
         for (int i = 1; i < NSTATES; i++) pm[i] <= INIT_V;
         cnt <= '0;
      end else if (start) begin
         pm[0] <= '0;
         for (int i = 1; i < NSTATES; i++) pm[i] <= INIT_V;
         cnt <= '0;
      end else if (accept) begin
         for (int i = 0; i < NSTATES; i++) pm[i] <= pm_next[i];
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // Decision outputs hold their last value on cycles without an accepted step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_valid  <= 1'b0;
         frame_done <= 1'b0;
         dec_bits   <= '0;
         dec_idx    <= '0;
         best_state <= '0;
      end else begin
         dec_valid  <= accept;
         frame_done <= accept && (cnt == LAST);
         if (accept) begin
            dec_bits   <= sel;
            dec_idx    <= cnt;
            best_state <= min_idx;
         end
      end
   end
endmodule

// File: tb/tb_path_metric_unit.sv
// Directed and randomised checks of path_metric_unit against hand values and a forward trellis model.
module tb_path_metric_unit;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        bm_valid;
   logic [31:0] bm_in;
   logic        dec_valid;
   logic [7:0]  dec_bits;
   logic [3:0]  dec_idx;
   logic [2:0]  best_state;
   logic        frame_done;

   int checks;
   int errors;

   logic [4:0] exp_pm [8];
   int         m_pm [8];
   int         m_cnt;
   bit         m_run;

   path_metric_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bm_valid   (bm_valid),
      .bm_in      (bm_in),
      .dec_valid  (dec_valid),
      .dec_bits   (dec_bits),
      .dec_idx    (dec_idx),
      .best_state (best_state),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_start();
      @(negedge clk);
      start    = 1'b1;
      bm_valid = 1'b0;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic step(input logic [31:0] bm);
      @(negedge clk);
      start    = 1'b0;
      bm_valid = 1'b1;
      bm_in    = bm;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bm_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Forward formulation: visit every (source, input) edge in ascending source order.
   task automatic model_step(input logic [31:0] bm, output logic [7:0] bits, output logic [2:0] best);
      int s;
      int n;
      int best_sum [8];
      int m;
      for (int i = 0; i < 8; i++) best_sum[i] = 1000;
      bits = 8'h00;
      for (int p = 0; p < 8; p++) begin
         for (int b = 0; b < 2; b++) begin
            n = b * 4 + p / 2;
            s = m_pm[p] + int'(bm[4*p + 2*b +: 2]);
            if (s > 31) s = 31;
            if (s < best_sum[n]) begin
               best_sum[n] = s;
               bits[n] = p[0];
            end
         end
      end
      m = 1000;
      best = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (best_sum[i] < m) begin
            m = best_sum[i];
            best = 3'(i);
         end
      end
      for (int i = 0; i < 8; i++) m_pm[i] = best_sum[i] - m;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bm_valid = 1'b0; bm_in = '0;
      #12;
      exp_pm = '{5'd0, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15};
      checks++;
      if ({dec_valid, dec_bits, dec_idx, best_state, frame_done} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {dec_valid, dec_bits, dec_idx, best_state, frame_done});
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL reset_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ignored_before_start();
      for (int k = 0; k < 3; k++) begin
         step(32'h0);
         checks++;
         if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore cycle %0d dec_valid got %b want 0", k, dec_valid);
         end
      end
      idle_cycle();
   endtask

   task automatic test_single_zero();
      do_start();
      step(32'h0);
      exp_pm = '{5'd0, 5'd15, 5'd15, 5'd15, 5'd0, 5'd15, 5'd15, 5'd15};
      checks++;
      if ({dec_valid, dec_bits, dec_idx, best_state, frame_done} !== {1'b1, 8'h00, 4'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL single_zero outputs got v=%b bits=%h idx=%0d best=%0d fd=%b want v=1 bits=00 idx=0 best=0 fd=0",
                  dec_valid, dec_bits, dec_idx, best_state, frame_done);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL single_zero_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      idle_cycle();
      checks++;
      if ({dec_valid, frame_done, dec_idx} !== {1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL idle_after_step got v=%b fd=%b idx=%0d want v=0 fd=0 idx=0", dec_valid, frame_done, dec_idx);
      end
   endtask

   task automatic test_normalisation();
      do_start();
      step(32'h0000000A);
      exp_pm = '{5'd0, 5'd13, 5'd13, 5'd13, 5'd0, 5'd13, 5'd13, 5'd13};
      checks++;
      if ({dec_bits, best_state} !== {8'h00, 3'd0}) begin
         errors++;
         $display("FAIL norm_outputs got bits=%h best=%0d want bits=00 best=0", dec_bits, best_state);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL norm_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      idle_cycle();
   endtask

   task automatic test_odd_pred();
      do_start();
      step(32'h0);
      step(32'h0000000F);
      exp_pm = '{5'd3, 5'd15, 5'd0, 5'd15, 5'd3, 5'd15, 5'd0, 5'd15};
      checks++;
      if ({dec_bits[4], dec_bits[0], best_state} !== {1'b0, 1'b0, 3'd2}) begin
         errors++;
         $display("FAIL odd_step2 got bits=%h best=%0d want bit4=0 bit0=0 best=2", dec_bits, best_state);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL odd_step2_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      step(32'h0);
      checks++;
      if ({dec_bits, best_state, dut.pm[1], dut.pm[0]} !== {8'h00, 3'd1, 5'd0, 5'd3}) begin
         errors++;
         $display("FAIL odd_step3 got bits=%h best=%0d pm1=%0d pm0=%0d want bits=00 best=1 pm1=0 pm0=3",
                  dec_bits, best_state, dut.pm[1], dut.pm[0]);
      end
      step(32'h0);
      checks++;
      if ({dec_bits, best_state} !== {8'hFF, 3'd0}) begin
         errors++;
         $display("FAIL odd_select got bits=%h best=%0d want bits=ff best=0", dec_bits, best_state);
      end
      step(32'h0);
      checks++;
      if ({dec_bits, best_state, dec_idx} !== {8'h00, 3'd0, 4'd4}) begin
         errors++;
         $display("FAIL tie_even got bits=%h best=%0d idx=%0d want bits=00 best=0 idx=4", dec_bits, best_state, dec_idx);
      end
      idle_cycle();
   endtask

   task automatic test_frame_wrap();
      do_start();
      for (int i = 0; i < 17; i++) begin
         step(32'h0);
         checks++;
         if ({dec_valid, dec_idx, frame_done} !== {1'b1, 4'(i % 16), (i == 15)}) begin
            errors++;
            $display("FAIL wrap step %0d got v=%b idx=%0d fd=%b want v=1 idx=%0d fd=%b",
                     i, dec_valid, dec_idx, frame_done, i % 16, (i == 15));
         end
      end
      idle_cycle();
      checks++;
      if ({dec_valid, frame_done} !== 2'b00) begin
         errors++;
         $display("FAIL wrap_idle got v=%b fd=%b want 0 0", dec_valid, frame_done);
      end
   endtask

   task automatic test_start_priority();
      do_start();
      step(32'h0);
      step(32'h0000000F);
      @(negedge clk);
      start = 1'b1; bm_valid = 1'b1; bm_in = 32'h0000000F;
      @(posedge clk);
      #1;
      exp_pm = '{5'd0, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15};
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_priority dec_valid got %b want 0", dec_valid);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL start_reinit_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      step(32'h0);
      checks++;
      if ({dec_valid, dec_idx, dut.pm[4]} !== {1'b1, 4'd0, 5'd0}) begin
         errors++;
         $display("FAIL after_start got v=%b idx=%0d pm4=%0d want v=1 idx=0 pm4=0", dec_valid, dec_idx, dut.pm[4]);
      end
      idle_cycle();
   endtask

   task automatic test_reset_mid_frame();
      do_start();
      step(32'h0);
      step(32'h0000000F);
      #2;
      rst_n = 1'b0;
      #1;
      exp_pm = '{5'd0, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15};
      checks++;
      if ({dec_valid, dec_bits, dec_idx, best_state, frame_done} !== 17'd0) begin
         errors++;
         $display("FAIL async_reset_outputs got %h want 0", {dec_valid, dec_bits, dec_idx, best_state, frame_done});
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut.pm[i] !== exp_pm[i]) begin
            errors++;
            $display("FAIL async_reset_pm[%0d] got %0d want %0d", i, dut.pm[i], exp_pm[i]);
         end
      end
      @(negedge clk);
      bm_valid = 1'b0;
      rst_n    = 1'b1;
      step(32'h0);
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle dec_valid got %b want 0", dec_valid);
      end
      idle_cycle();
   endtask

   task automatic test_soak();
      logic        s;
      logic        v;
      logic [31:0] b;
      logic        acc;
      logic [7:0]  e_bits;
      logic [2:0]  e_best;
      logic [3:0]  e_idx;
      logic        e_fd;
      m_run = 1'b0;
      m_cnt = 0;
      m_pm[0] = 0;
      for (int i = 1; i < 8; i++) m_pm[i] = 15;
      e_bits = '0; e_best = '0; e_idx = '0; e_fd = 1'b0;
      for (int k = 0; k < 400; k++) begin
         s = ($urandom_range(0, 9) == 0);
         v = ($urandom_range(0, 3) != 0);
         b = $urandom;
         @(negedge clk);
         start = s; bm_valid = v; bm_in = b;
         acc = m_run && v && !s;
         if (s) begin
            m_run = 1'b1;
            m_cnt = 0;
            m_pm[0] = 0;
            for (int i = 1; i < 8; i++) m_pm[i] = 15;
         end else if (acc) begin
            model_step(b, e_bits, e_best);
            e_idx = 4'(m_cnt);
            e_fd  = (m_cnt == 15);
            m_cnt = (m_cnt == 15) ? 0 : m_cnt + 1;
         end
         @(posedge clk);
         #1;
         checks++;
         if (dec_valid !== acc) begin
            errors++;
            $display("FAIL soak_valid cycle %0d got %b want %b", k, dec_valid, acc);
         end
         if (acc) begin
            checks++;
            if ({dec_bits, best_state, dec_idx, frame_done} !== {e_bits, e_best, e_idx, e_fd}) begin
               errors++;
               $display("FAIL soak_dec cycle %0d got bits=%h best=%0d idx=%0d fd=%b want bits=%h best=%0d idx=%0d fd=%b",
                        k, dec_bits, best_state, dec_idx, frame_done, e_bits, e_best, e_idx, e_fd);
            end
         end else begin
            checks++;
            if (frame_done !== 1'b0) begin
               errors++;
               $display("FAIL soak_fd_idle cycle %0d got %b want 0", k, frame_done);
            end
         end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.pm[i] !== 5'(m_pm[i])) begin
               errors++;
               $display("FAIL soak_pm[%0d] cycle %0d got %0d want %0d", i, k, dut.pm[i], m_pm[i]);
            end
         end
      end
      start = 1'b0;
      bm_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_ignored_before_start();
      test_single_zero();
      test_normalisation();
      test_odd_pred();
      test_frame_wrap();
      test_start_priority();
      test_reset_mid_frame();
      test_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
